// File: rtl/host_wrfifo.sv
// host_wrfifo: host bus write buffer for the VGA text terminal.
// Synchronises the asynchronous ncs/nwr/nrd strobes, captures each host
// register write into a FIFO (with a one-entry overflow holding register),
// and drains entries to the control block over a valid/ready handshake.
// Optional build macro: WRFIFO_STATUS_EN adds the fifo_level occupancy port.
module host_wrfifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     ncs,
  input  logic                     nwr,
  input  logic                     nrd,
  input  logic [AW-1:0]            ext_address,
  input  logic [DW-1:0]            ext_data_in,
  output logic                     wait_sig,
  output logic                     rd_allow,
  output logic                     wr_valid,
  output logic [AW-1:0]            wr_address,
  output logic [DW-1:0]            wr_data,
  input  logic                     wr_ready
`ifdef WRFIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0]   fifo_level
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  // Strobes packed so one generate loop builds all three synchronisers.
  logic [2:0] strobe_raw;
  logic [2:0] strobe_s;
  assign strobe_raw = {nrd, nwr, ncs};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [1:0] stage_reg;
      // Two-flop synchroniser; idles high so reset looks like "no strobe".
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) stage_reg <= 2'b11;
        else       stage_reg <= {stage_reg[0], strobe_raw[gi]};
      end
      assign strobe_s[gi] = stage_reg[1];
    end
  endgenerate

  logic wr_act, rd_act, wr_event;
  logic wr_act_prev_reg;
  assign wr_act   = !strobe_s[0] && !strobe_s[1];
  assign rd_act   = !strobe_s[0] && !strobe_s[2];
  assign wr_event = wr_act && !wr_act_prev_reg;

  logic [EW-1:0] mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          pend_v_reg;
  logic [EW-1:0] pend_reg;
  logic [EW-1:0] hold_reg;
  logic          wait_reg, rd_allow_reg;

  logic          full, empty, push, pop;
  logic [EW-1:0] push_word, head_word, bus_word;

  assign bus_word  = {ext_address, ext_data_in};
  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  // A pending entry always goes first so write order is never broken.
  assign push      = !full && (pend_v_reg || wr_event);
  assign push_word = pend_v_reg ? pend_reg : bus_word;
  assign pop       = !empty && wr_ready;
  assign head_word = mem_reg[rd_ptr_reg];

  // Storage array; no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= push_word;
  end

  // Occupancy counter update.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers, count, pending slot, last-popped hold and registered strobes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_act_prev_reg <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      pend_v_reg      <= 1'b0;
      pend_reg        <= '0;
      hold_reg        <= '0;
      wait_reg        <= 1'b0;
      rd_allow_reg    <= 1'b0;
    end else begin
      wr_act_prev_reg <= wr_act;
      count_reg       <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
        hold_reg   <= head_word;
      end
      if (wr_event && (full || pend_v_reg)) begin
        pend_v_reg <= 1'b1;
        pend_reg   <= bus_word;
      end else if (pend_v_reg && !full) begin
        pend_v_reg <= 1'b0;
      end
      wait_reg     <= pend_v_reg || (full && wr_act) || (rd_act && !empty);
      rd_allow_reg <= rd_act && empty && !pend_v_reg;
    end
  end

  // Head is shown while valid; the last popped entry is held when empty.
  assign wr_valid                = !empty;
  assign {wr_address, wr_data}   = empty ? hold_reg : head_word;
  assign wait_sig                = wait_reg;
  assign rd_allow                = rd_allow_reg;

`ifdef WRFIFO_STATUS_EN
  assign fifo_level = count_reg;
`endif

endmodule

// File: tb/tb_host_wrfifo.sv
// Directed self-checking bench for host_wrfifo (DEPTH=8, AW=4, DW=8).
module tb_host_wrfifo;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       ncs = 1'b1, nwr = 1'b1, nrd = 1'b1;
  logic [3:0] ext_address = '0;
  logic [7:0] ext_data_in = '0;
  logic       wait_sig, rd_allow, wr_valid;
  logic [3:0] wr_address;
  logic [7:0] wr_data;
  logic       wr_ready = 1'b0;
`ifdef WRFIFO_STATUS_EN
  logic [3:0] fifo_level;
`endif

  int errors = 0;
  int checks = 0;

  host_wrfifo #(.DEPTH(8), .AW(4), .DW(8)) dut (
    .clk(clk), .nrst(nrst), .ncs(ncs), .nwr(nwr), .nrd(nrd),
    .ext_address(ext_address), .ext_data_in(ext_data_in),
    .wait_sig(wait_sig), .rd_allow(rd_allow), .wr_valid(wr_valid),
    .wr_address(wr_address), .wr_data(wr_data), .wr_ready(wr_ready)
`ifdef WRFIFO_STATUS_EN
    , .fifo_level(fifo_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-clock write strobe; address/data stay driven afterwards.
  task automatic pulse_write(input logic [3:0] a, input logic [7:0] d);
    ext_address = a;
    ext_data_in = d;
    ncs = 1'b0;
    nwr = 1'b0;
    cyc();
    ncs = 1'b1;
    nwr = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    cyc(); cyc();
    checks++;
    if ({wait_sig, rd_allow, wr_valid, wr_address, wr_data} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {wait_sig, rd_allow, wr_valid, wr_address, wr_data});
    end
`ifdef WRFIFO_STATUS_EN
    checks++;
    if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
`endif
    nrst = 1'b1;
    cyc();
    $display("reset: outputs checked");
  endtask

  task automatic test_single_write();
    wr_ready = 1'b1;
    pulse_write(4'h3, 8'hA5);
    checks++;
    if (wr_valid !== 1'b0) begin errors++; $display("FAIL single_early1 valid=%b exp=0", wr_valid); end
    cyc();
    checks++;
    if (wr_valid !== 1'b0) begin errors++; $display("FAIL single_early2 valid=%b exp=0", wr_valid); end
    cyc();
    checks++;
    if ({wr_valid, wr_address, wr_data, wait_sig} !== {1'b1, 4'h3, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL single_head valid=%b addr=%h data=%h wait=%b exp 1/3/a5/0", wr_valid, wr_address, wr_data, wait_sig);
    end
    cyc();
    checks++;
    if ({wr_valid, wr_address, wr_data, wait_sig} !== {1'b0, 4'h3, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL single_after valid=%b addr=%h data=%h wait=%b exp 0/3/a5/0", wr_valid, wr_address, wr_data, wait_sig);
    end
    repeat (3) cyc();
    $display("single_write: addr=3 data=a5");
  endtask

  task automatic test_full_pending();
    wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pulse_write(i[3:0], i[7:0]);
      repeat (3) cyc();
    end
    checks++;
    if ({wait_sig, wr_valid, wr_data} !== {1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL full_eight wait=%b valid=%b data=%h exp 0/1/00", wait_sig, wr_valid, wr_data);
    end
    pulse_write(4'h8, 8'h08);
    cyc(); cyc();
    checks++;
    if (wait_sig !== 1'b1) begin errors++; $display("FAIL full_wait_rise wait=%b exp=1", wait_sig); end
    cyc(); cyc();
    checks++;
    if (wait_sig !== 1'b1) begin errors++; $display("FAIL full_wait_hold wait=%b exp=1", wait_sig); end
    wr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if ({wr_valid, wr_address, wr_data} !== {1'b1, i[3:0], i[7:0]}) begin
        errors++;
        $display("FAIL full_pop%0d valid=%b addr=%h data=%h exp 1/%h/%h", i, wr_valid, wr_address, wr_data, i[3:0], i[7:0]);
      end
      cyc();
    end
    checks++;
    if ({wr_valid, wait_sig} !== 2'b00) begin
      errors++;
      $display("FAIL full_drained valid=%b wait=%b exp 0/0", wr_valid, wait_sig);
    end
    wr_ready = 1'b0;
    cyc();
    $display("full_pending: 9 entries drained in order");
  endtask

  task automatic test_read_order();
    wr_ready = 1'b0;
    pulse_write(4'h2, 8'h11);
    repeat (3) cyc();
    ncs = 1'b0;
    nrd = 1'b0;
    repeat (4) cyc();
    checks++;
    if ({wait_sig, rd_allow, wr_valid, wr_data} !== {1'b1, 1'b0, 1'b1, 8'h11}) begin
      errors++;
      $display("FAIL read_blocked wait=%b rd_allow=%b valid=%b data=%h exp 1/0/1/11", wait_sig, rd_allow, wr_valid, wr_data);
    end
    wr_ready = 1'b1;
    cyc();
    checks++;
    if ({wr_valid, rd_allow, wait_sig} !== 3'b001) begin
      errors++;
      $display("FAIL read_popped valid=%b rd_allow=%b wait=%b exp 0/0/1", wr_valid, rd_allow, wait_sig);
    end
    cyc();
    checks++;
    if ({rd_allow, wait_sig} !== 2'b10) begin
      errors++;
      $display("FAIL read_allowed rd_allow=%b wait=%b exp 1/0", rd_allow, wait_sig);
    end
    ncs = 1'b1;
    nrd = 1'b1;
    cyc(); cyc();
    checks++;
    if (rd_allow !== 1'b1) begin errors++; $display("FAIL read_allow_hold rd_allow=%b exp=1", rd_allow); end
    cyc();
    checks++;
    if (rd_allow !== 1'b0) begin errors++; $display("FAIL read_allow_fall rd_allow=%b exp=0", rd_allow); end
    wr_ready = 1'b0;
    cyc();
    $display("read_order: read waited for write 11");
  endtask

  task automatic test_stream();
    int         nv;
    logic [11:0] cap;
    wr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      nv  = 0;
      cap = '0;
      pulse_write(4'(k + 1), 8'(8'h30 + k));
      for (int j = 0; j < 4; j++) begin
        if (wr_valid === 1'b1) begin
          nv++;
          cap = {wr_address, wr_data};
        end
`ifdef WRFIFO_STATUS_EN
        checks++;
        if (fifo_level > 4'd1) begin errors++; $display("FAIL stream_level got=%0d exp<=1", fifo_level); end
`endif
        if (j < 3) cyc();
      end
      checks++;
      if (nv !== 1 || cap !== {4'(k + 1), 8'(8'h30 + k)}) begin
        errors++;
        $display("FAIL stream%0d valid_cycles=%0d entry=%h exp 1/%h", k, nv, cap, {4'(k + 1), 8'(8'h30 + k)});
      end
      $display("stream: write %0d entry=%h", k, cap);
    end
    cyc();
  endtask

  task automatic test_reset_mid_drain();
    int         nv;
    logic [11:0] cap;
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse_write(4'h4, 8'(8'h40 + i));
      repeat (3) cyc();
    end
    checks++;
    if ({wr_valid, wr_data} !== {1'b1, 8'h40}) begin
      errors++;
      $display("FAIL mid_filled valid=%b data=%h exp 1/40", wr_valid, wr_data);
    end
    wr_ready = 1'b1;
    cyc(); cyc();
    checks++;
    if (wr_data !== 8'h42) begin errors++; $display("FAIL mid_head data=%h exp=42", wr_data); end
    nrst = 1'b0;
    #1;
    checks++;
    if ({wr_valid, wait_sig, wr_address, wr_data} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset valid=%b wait=%b addr=%h data=%h exp all 0", wr_valid, wait_sig, wr_address, wr_data);
    end
`ifdef WRFIFO_STATUS_EN
    checks++;
    if (fifo_level !== 4'd0) begin errors++; $display("FAIL mid_reset_level got=%0d exp=0", fifo_level); end
`endif
    cyc();
    nrst = 1'b1;
    cyc();
    nv  = 0;
    cap = '0;
    pulse_write(4'h7, 8'h5A);
    for (int j = 0; j < 6; j++) begin
      if (wr_valid === 1'b1) begin
        nv++;
        cap = {wr_address, wr_data};
      end
      cyc();
    end
    checks++;
    if (nv !== 1 || cap !== 12'h75A) begin
      errors++;
      $display("FAIL mid_after valid_cycles=%0d entry=%h exp 1/75a", nv, cap);
    end
    $display("reset_mid_drain: post-reset entry=%h", cap);
  endtask

  task automatic test_no_cs();
    int nv;
    nv = 0;
    wr_ready = 1'b1;
    ext_address = 4'hF;
    ext_data_in = 8'hFF;
    ncs = 1'b1;
    nwr = 1'b0;
    cyc();
    nwr = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (wr_valid !== 1'b0) nv++;
      cyc();
    end
    checks++;
    if (nv !== 0 || {wr_address, wr_data} !== 12'h75A) begin
      errors++;
      $display("FAIL no_cs valid_cycles=%0d entry=%h exp 0/75a", nv, {wr_address, wr_data});
    end
    $display("no_cs: nwr pulse ignored");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full_pending();
    test_read_order();
    test_stream();
    test_reset_mid_drain();
    test_no_cs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded bound");
    $fatal(1);
  end

endmodule
